// File: rtl/riscv_crypto_pkg.sv
// Shared SSM3 helpers: rotate function, rotate amounts, legal parameter ranges.
// Used by riscv_crypto_fu_ssm3_pipe and riscv_crypto_pipe_slice.
package riscv_crypto_pkg;

    localparam int unsigned SSM3_W          = 32;
    localparam int unsigned XLEN_RV32       = 32;
    localparam int unsigned XLEN_RV64       = 64;
    localparam int unsigned PIPE_STAGES_MIN = 1;
    localparam int unsigned PIPE_STAGES_MAX = 4;

    localparam logic [4:0] SSM3_P0_ROT_A = 5'd9;
    localparam logic [4:0] SSM3_P0_ROT_B = 5'd17;
    localparam logic [4:0] SSM3_P1_ROT_A = 5'd15;
    localparam logic [4:0] SSM3_P1_ROT_B = 5'd23;

    typedef struct packed {
        logic p0;
        logic p1;
    } ssm3_op_t;

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] sh);
        return (x << sh) | (x >> (6'd32 - {1'b0, sh}));
    endfunction

    function automatic bit xlen_is_legal(input int unsigned xlen);
        return (xlen == XLEN_RV32) || (xlen == XLEN_RV64);
    endfunction

    function automatic bit pipe_stages_is_legal(input int unsigned n);
        return (n >= PIPE_STAGES_MIN) && (n <= PIPE_STAGES_MAX);
    endfunction

endpackage

// File: rtl/riscv_crypto_pipe_slice.sv
// One elastic pipeline register: valid bit plus data/tag, with load, flush and
// synchronous active-low reset. Flush clears only the valid bit.
module riscv_crypto_pipe_slice
    import riscv_crypto_pkg::*;
#(
    parameter int unsigned DATA_W = SSM3_W,
    parameter int unsigned TAG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [TAG_W-1:0]  tag_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    // Payload only changes when a valid item lands, keeping idle outputs quiet.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
                tag_d  = tag_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/riscv_crypto_fu_ssm3_pipe.sv
// Pipelined SM3 P0/P1 functional unit with valid/ready on both sides, flush and tag.
// Optional retire counter port perf_count enabled by RISCV_CRYPTO_FU_SSM3_PERF_EN.
module riscv_crypto_fu_ssm3_pipe
    import riscv_crypto_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned TAG_W       = 5
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  rs1,
    input  logic             op_ssm3_p0,
    input  logic             op_ssm3_p1,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  rd,
    output logic [TAG_W-1:0] out_tag
`ifdef RISCV_CRYPTO_FU_SSM3_PERF_EN
    ,
    output logic [31:0]      perf_count
`endif
);

    localparam int unsigned LAST = PIPE_STAGES - 1;

    if (!xlen_is_legal(XLEN)) begin : g_bad_xlen
        $error("riscv_crypto_fu_ssm3_pipe: XLEN must be 32 or 64");
    end
    if (!pipe_stages_is_legal(PIPE_STAGES)) begin : g_bad_stages
        $error("riscv_crypto_fu_ssm3_pipe: PIPE_STAGES must be 1..4");
    end

    ssm3_op_t          op_c;
    logic [SSM3_W-1:0] x_c, p0_c, p1_c, res_c;
    logic              in_fire_c;

    logic              stg_valid [PIPE_STAGES];
    logic [SSM3_W-1:0] stg_data  [PIPE_STAGES];
    logic [TAG_W-1:0]  stg_tag   [PIPE_STAGES];

    // Permutations and op select, evaluated before stage 0.
    assign op_c  = '{p0: op_ssm3_p0, p1: op_ssm3_p1};
    assign x_c   = rs1[SSM3_W-1:0];
    assign p0_c  = x_c ^ rol32(x_c, SSM3_P0_ROT_A) ^ rol32(x_c, SSM3_P0_ROT_B);
    assign p1_c  = x_c ^ rol32(x_c, SSM3_P1_ROT_A) ^ rol32(x_c, SSM3_P1_ROT_B);
    assign res_c = ({SSM3_W{op_c.p0}} & p0_c) | ({SSM3_W{op_c.p1}} & p1_c);

    assign in_ready  = g_resetn & ~flush & g_stage[0].load_c;
    assign in_fire_c = in_valid & in_ready;

    // Each stage loads when empty or when its content can move downstream.
    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
        logic              load_c;
        logic              valid_in_c;
        logic [SSM3_W-1:0] data_in_c;
        logic [TAG_W-1:0]  tag_in_c;

        if (i == 0) begin : g_src_in
            assign valid_in_c = in_fire_c;
            assign data_in_c  = res_c;
            assign tag_in_c   = in_tag;
        end else begin : g_src_prev
            assign valid_in_c = stg_valid[i-1];
            assign data_in_c  = stg_data[i-1];
            assign tag_in_c   = stg_tag[i-1];
        end

        if (i == LAST) begin : g_ld_last
            assign load_c = ~stg_valid[i] | out_ready;
        end else begin : g_ld_mid
            assign load_c = ~stg_valid[i] | g_stage[i+1].load_c;
        end

        riscv_crypto_pipe_slice #(
            .DATA_W (SSM3_W),
            .TAG_W  (TAG_W)
        ) u_slice (
            .clk_i   (g_clk),
            .rst_ni  (g_resetn),
            .flush_i (flush),
            .load_i  (load_c),
            .valid_i (valid_in_c),
            .data_i  (data_in_c),
            .tag_i   (tag_in_c),
            .valid_o (stg_valid[i]),
            .data_o  (stg_data[i]),
            .tag_o   (stg_tag[i])
        );
    end

    assign out_valid = stg_valid[LAST];
    assign out_tag   = stg_tag[LAST];

    // On RV64 the 32-bit result is sign-extended and the upper source half ignored.
    if (XLEN > SSM3_W) begin : g_sext
        logic unused_rs1_hi;
        assign unused_rs1_hi = ^rs1[XLEN-1:SSM3_W];
        assign rd = {{(XLEN - SSM3_W){stg_data[LAST][SSM3_W-1]}}, stg_data[LAST]};
    end else begin : g_nosext
        assign rd = stg_data[LAST];
    end

`ifdef RISCV_CRYPTO_FU_SSM3_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Counts retirements; a flushed handshake is not a retirement.
    always_comb begin
        perf_d = perf_q;
        if (out_valid & out_ready & ~flush) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_count = perf_q;
`endif

endmodule

// File: tb/tb_riscv_crypto_fu_ssm3_pipe.sv
// Bench for riscv_crypto_fu_ssm3_pipe: an RV32/2-stage and an RV64/3-stage instance
// share stimulus; a queue model checks every cycle, plus literal expectations.
module tb_riscv_crypto_fu_ssm3_pipe;

    localparam int unsigned TAG_W = 5;
    localparam int unsigned PS_A  = 2;
    localparam int unsigned PS_B  = 3;

    logic             g_clk;
    logic             g_resetn;
    logic             flush;
    logic             in_valid;
    logic [63:0]      rs1;
    logic             op_p0;
    logic             op_p1;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             a_in_ready, a_out_valid;
    logic [31:0]      a_rd;
    logic [TAG_W-1:0] a_tag;
    logic             b_in_ready, b_out_valid;
    logic [63:0]      b_rd;
    logic [TAG_W-1:0] b_tag;
`ifdef RISCV_CRYPTO_FU_SSM3_PERF_EN
    logic [31:0]      a_perf, b_perf;
`endif

    int n_vec;
    int n_err;
    bit chk_en;

    riscv_crypto_fu_ssm3_pipe #(.XLEN(32), .PIPE_STAGES(PS_A), .TAG_W(TAG_W)) dut32 (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (a_in_ready),
        .rs1        (rs1[31:0]),
        .op_ssm3_p0 (op_p0),
        .op_ssm3_p1 (op_p1),
        .in_tag     (in_tag),
        .out_valid  (a_out_valid),
        .out_ready  (out_ready),
        .rd         (a_rd),
        .out_tag    (a_tag)
`ifdef RISCV_CRYPTO_FU_SSM3_PERF_EN
        ,
        .perf_count (a_perf)
`endif
    );

    riscv_crypto_fu_ssm3_pipe #(.XLEN(64), .PIPE_STAGES(PS_B), .TAG_W(TAG_W)) dut64 (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (b_in_ready),
        .rs1        (rs1),
        .op_ssm3_p0 (op_p0),
        .op_ssm3_p1 (op_p1),
        .in_tag     (in_tag),
        .out_valid  (b_out_valid),
        .out_ready  (out_ready),
        .rd         (b_rd),
        .out_tag    (b_tag)
`ifdef RISCV_CRYPTO_FU_SSM3_PERF_EN
        ,
        .perf_count (b_perf)
`endif
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: an in-order queue of accepted ops ----------------
    typedef struct packed {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        logic [31:0]      t;
    } ent_t;

    ent_t        q0[$];
    ent_t        q1[$];
    logic [31:0] cyc;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[63-n -: 32];
    endfunction

    function automatic logic [31:0] model_res(input logic [31:0] x, input logic s0, input logic s1);
        logic [31:0] r;
        r = 32'h0;
        if (s0) r = r | (x ^ rotl(x, 9) ^ rotl(x, 17));
        if (s1) r = r | (x ^ rotl(x, 15) ^ rotl(x, 23));
        return r;
    endfunction

    function automatic int unsigned occ(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic ent_t head(input int i);
        ent_t e;
        e = '0;
        if (i == 0 && q0.size() > 0) e = q0[0];
        if (i == 1 && q1.size() > 0) e = q1[0];
        return e;
    endfunction

    function automatic int unsigned ps(input int i);
        return (i == 0) ? PS_A : PS_B;
    endfunction

    // The oldest op is never blocked, so it is visible PIPE_STAGES cycles after acceptance.
    function automatic bit ov_exp(input int i);
        ent_t e;
        e = head(i);
        return (occ(i) > 0) && (cyc >= e.t + ps(i) - 1);
    endfunction

    // Pipe bubbles compress, so the unit is ready unless full and not retiring.
    function automatic bit ir_exp(input int i);
        return g_resetn && !flush && ((occ(i) < ps(i)) || (ov_exp(i) && out_ready));
    endfunction

    function automatic logic [63:0] rd_exp(input int i);
        ent_t e;
        e = head(i);
        return (i == 0) ? {32'h0, e.res} : {{32{e.res[31]}}, e.res};
    endfunction

    bit   pop0, pop1, push0, push1;
    ent_t ne;

    always @(posedge g_clk) begin
        pop0   = ov_exp(0) && out_ready;
        pop1   = ov_exp(1) && out_ready;
        push0  = in_valid && ir_exp(0);
        push1  = in_valid && ir_exp(1);
        ne.res = model_res(rs1[31:0], op_p0, op_p1);
        ne.tag = in_tag;
        ne.t   = cyc + 32'd1;
        if (!g_resetn || flush) begin
            q0.delete();
            q1.delete();
        end else begin
            if (pop0) void'(q0.pop_front());
            if (pop1) void'(q1.pop_front());
            if (push0) q0.push_back(ne);
            if (push1) q1.push_back(ne);
        end
        cyc = cyc + 32'd1;
    end

    always @(negedge g_clk) begin
        if (chk_en) begin
            chk("a_in_ready", 64'(a_in_ready), 64'(ir_exp(0)));
            chk("a_out_valid", 64'(a_out_valid), 64'(ov_exp(0)));
            chk("b_in_ready", 64'(b_in_ready), 64'(ir_exp(1)));
            chk("b_out_valid", 64'(b_out_valid), 64'(ov_exp(1)));
            if (ov_exp(0)) begin
                chk("a_rd", {32'h0, a_rd}, rd_exp(0));
                chk("a_tag", 64'(a_tag), 64'(head(0).tag));
            end
            if (ov_exp(1)) begin
                chk("b_rd", b_rd, rd_exp(1));
                chk("b_tag", 64'(b_tag), 64'(head(1).tag));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic send(input logic [63:0] x, input logic s0, input logic s1, input logic [TAG_W-1:0] tg);
        rs1      = x;
        op_p0    = s0;
        op_p1    = s1;
        in_tag   = tg;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    int          k;
    int          nout;
    logic [63:0] last_rd;

    initial begin
        g_resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; rs1 = 64'h0;
        op_p0 = 1'b0; op_p1 = 1'b0; in_tag = '0; out_ready = 1'b1;
        n_vec = 0; n_err = 0; chk_en = 1'b0; cyc = 32'h0;

        step();
        step();
        chk_en = 1'b1;
        chk("rst_a_out_valid", 64'(a_out_valid), 64'h0);
        chk("rst_a_rd", 64'(a_rd), 64'h0);
        chk("rst_a_tag", 64'(a_tag), 64'h0);
        chk("rst_b_rd", b_rd, 64'h0);
        chk("rst_a_in_ready", 64'(a_in_ready), 64'h0);
        g_resetn = 1'b1;
        step();

        // P0 of 1, latency 2 on the RV32 unit and 3 on the RV64 unit
        send(64'h1, 1'b1, 1'b0, 5'd3);
        chk("p0_lat_early", 64'(a_out_valid), 64'h0);
        step();
        chk("p0_lat_valid", 64'(a_out_valid), 64'h1);
        chk("p0_rd", 64'(a_rd), 64'h0002_0201);
        chk("p0_tag", 64'(a_tag), 64'h3);
        step();
        chk("p0_b_valid", 64'(b_out_valid), 64'h1);
        chk("p0_b_rd", b_rd, 64'h0000_0000_0002_0201);

        send(64'h1, 1'b0, 1'b1, 5'd5);
        step();
        chk("p1_rd", 64'(a_rd), 64'h0080_8001);
        chk("p1_tag", 64'(a_tag), 64'h5);
        step();
        chk("p1_b_rd", b_rd, 64'h0000_0000_0080_8001);

        send(64'hDEAD_BEEF_8000_0000, 1'b1, 1'b0, 5'd9);
        step();
        chk("rv32_p0_hi", 64'(a_rd), 64'h8001_0100);
        step();
        chk("rv64_p0_sext", b_rd, 64'hFFFF_FFFF_8001_0100);

        send(64'hDEAD_BEEF_8000_0000, 1'b0, 1'b1, 5'd10);
        step();
        step();
        chk("rv64_p1_sext", b_rd, 64'hFFFF_FFFF_8040_4000);

        send(64'h1, 1'b1, 1'b1, 5'd1);
        step();
        chk("both_ops", 64'(a_rd), 64'h0082_8201);

        send(64'h1, 1'b0, 1'b0, 5'd2);
        step();
        chk("no_op_valid", 64'(a_out_valid), 64'h1);
        chk("no_op_rd", 64'(a_rd), 64'h0);
        repeat (4) step();

        // Backpressure: stream five P0 ops into a stalled consumer
        out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (k < 5);
            rs1      = 64'(k + 1);
            op_p0    = 1'b1;
            op_p1    = 1'b0;
            in_tag   = TAG_W'(k);
            @(negedge g_clk);
            if (in_valid && b_in_ready) k++;
            step();
        end
        chk("bp_accepted", 64'(k), 64'h3);
        @(negedge g_clk);
        chk("bp_in_ready", 64'(b_in_ready), 64'h0);
        chk("bp_rd_stable", b_rd, 64'h0002_0201);
        step();
        out_ready = 1'b1;
        nout = 0;
        last_rd = 64'h0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (k < 5);
            rs1      = 64'(k + 1);
            in_tag   = TAG_W'(k);
            @(negedge g_clk);
            if (b_out_valid) begin
                nout++;
                last_rd = b_rd;
            end
            if (in_valid && b_in_ready) k++;
            step();
        end
        in_valid = 1'b0;
        chk("bp_all_accepted", 64'(k), 64'h5);
        chk("bp_back_to_back", 64'(nout), 64'h5);
        chk("bp_last_rd", last_rd, 64'h0000_0000_000A_0A05);
        repeat (6) step();

        // Flush with two ops in flight; an op offered during flush is refused
        send(64'h1, 1'b1, 1'b0, 5'd1);
        send(64'h2, 1'b1, 1'b0, 5'd2);
        rs1 = 64'h3; in_valid = 1'b1; flush = 1'b1;
        @(negedge g_clk);
        chk("flush_in_ready", 64'(a_in_ready), 64'h0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_a_valid", 64'(a_out_valid), 64'h0);
        chk("flush_b_valid", 64'(b_out_valid), 64'h0);
        send(64'h1, 1'b0, 1'b1, 5'd7);
        chk("post_flush_early", 64'(a_out_valid), 64'h0);
        step();
        chk("post_flush_valid", 64'(a_out_valid), 64'h1);
        chk("post_flush_rd", 64'(a_rd), 64'h0080_8001);
        chk("post_flush_tag", 64'(a_tag), 64'h7);
        step();
        chk("post_flush_b_tag", 64'(b_tag), 64'h7);
        repeat (3) step();

        // Reset mid-stream drops everything
        send(64'h1, 1'b1, 1'b0, 5'd4);
        rs1 = 64'h2; in_valid = 1'b1; g_resetn = 1'b0;
        step();
        in_valid = 1'b0;
        chk("midrst_a_valid", 64'(a_out_valid), 64'h0);
        chk("midrst_a_rd", 64'(a_rd), 64'h0);
        chk("midrst_b_valid", 64'(b_out_valid), 64'h0);
        chk("midrst_b_rd", b_rd, 64'h0);
        g_resetn = 1'b1;
        repeat (5) step();

`ifdef RISCV_CRYPTO_FU_SSM3_PERF_EN
        g_resetn = 1'b0;
        step();
        g_resetn = 1'b1;
        chk("perf_rst", 64'(a_perf), 64'h0);
        for (int c = 0; c < 10; c++) begin
            send(64'(c + 1), 1'b1, 1'b0, TAG_W'(c));
        end
        repeat (6) step();
        send(64'h9, 1'b0, 1'b1, 5'd9);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (2) step();
        chk("perf_a_10", 64'(a_perf), 64'd10);
        chk("perf_b_10", 64'(b_perf), 64'd10);
        force dut32.perf_q = 32'hFFFF_FFFF;
        #1;
        release dut32.perf_q;
        send(64'h1, 1'b1, 1'b0, 5'd1);
        repeat (4) step();
        chk("perf_wrap", 64'(a_perf), 64'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_crypto_fu_ssm3_pipe.md
Name: riscv_crypto_fu_ssm3_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle SSM3 P0/P1 functional unit.
- Computes the SM3 permutations P0 (x ^ rol(x,9) ^ rol(x,17)) and P1 (x ^ rol(x,15) ^ rol(x,23)) on the low 32 bits of rs1.
- Supports XLEN 32/64 and a configurable pipeline depth, with valid/ready handshakes on both sides, a flush input and a pass-through tag.
- Sits between the crypto issue stage and the writeback arbiter.

Parameters:
- XLEN, 32, datapath width; legal values are 32 or 64 only, checked at elaboration.
- PIPE_STAGES, 2, number of register slices, 1..4; this is also the latency in cycles.
- TAG_W, 5, width of the pass-through tag (destination register index).

Ports:
- g_clk  in  1  clock; all state updates on the rising edge.
- g_resetn  in  1  synchronous reset, active-low.
- flush  in  1  discard all in-flight operations.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- rs1  in  XLEN  source operand; only bits [31:0] are used.
- op_ssm3_p0  in  1  select P0.
- op_ssm3_p1  in  1  select P1.
- in_tag  in  TAG_W  tag carried alongside the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- rd  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset: g_resetn=0 at a clock edge clears every stage valid bit, data and tag.
  - out_valid=0, rd=0, out_tag=0.
  - in_ready=0 during the reset cycle.
  - Reset mid-operation drops all in-flight operations; nothing reaches the output.
- Compute:
  - P0/P1 are evaluated combinationally from the inputs and captured into stage 0 on the input handshake (in_valid & in_ready).
  - Stages 1..PIPE_STAGES-1 only forward data.
- Op select:
  - Result = ({32{p0}} & P0) | ({32{p1}} & P1).
  - Both ops set gives P0|P1; neither set gives 0. These are well-defined, not errors.
- Width:
  - XLEN=32: rd is the 32-bit result.
  - XLEN=64: rd is the 32-bit result sign-extended from bit 31; rs1[63:32] is ignored.
- Stage advance:
  - Stage i loads when it is empty or its content moves on this cycle.
  - The last stage's content moves on out_valid & out_ready.
  - in_ready is 1 when stage 0 is empty or stage 0 moves on this cycle (combinational from out_ready through the chain).
  - out_valid is the last stage's valid bit; rd and out_tag come from the last stage registers.
- Timing:
  - Latency is exactly PIPE_STAGES cycles from input handshake to out_valid when unstalled.
  - Throughput is 1 op/cycle.
- Backpressure:
  - Holding out_ready=0 fills the pipe; the unit then holds PIPE_STAGES results and in_ready drops to 0.
  - rd and out_tag stay stable while out_valid=1 and out_ready=0.
  - Full pipe plus out_ready=1 plus in_valid=1 accepts the new op and retires the oldest in the same cycle.
- Flush:
  - Next cycle, all stage valid bits are 0; data registers are don't-care.
  - in_ready=0 during the flush cycle; an in_valid in that cycle is not accepted.
  - Flush has priority over an output handshake in the same cycle: the consumer must ignore the result, and the perf counter does not count it.
  - Flush with reset: reset dominates.
- Ordering: results leave in acceptance order; no reordering.

Optional Feature:
- Macro: RISCV_CRYPTO_FU_SSM3_PERF_EN.
- Defined:
  - Adds output port perf_count [31:0], reset to 0.
  - Increments by 1 on each out_valid & out_ready with flush=0.
  - Wraps 0xFFFFFFFF -> 0; flush does not clear it.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package riscv_crypto_pkg:
  - rol32 function.
  - SSM3 rotate constants (9, 17, 15, 23).
  - Legal-XLEN constants and the elaboration-time parameter checks.
- Sub-module riscv_crypto_pipe_slice: one valid/data/tag register with load/flush/reset controls, instantiated PIPE_STAGES times via generate.
- The top level holds the P0/P1 datapath, op mux, sign extension, ready chain and optional counter.

Test Plan:
- XLEN=32, PIPE_STAGES=2, rs1=0x00000001:
  - p0 -> rd=0x00020201 after exactly 2 cycles.
  - p1 -> rd=0x00808001.
  - in_tag=3 -> out_tag=3.
- XLEN=64, rs1=0xDEADBEEF80000000:
  - p0 -> rd=0xFFFFFFFF80010100.
  - p1 -> rd=0xFFFFFFFF80404000.
- Op select, rs1=0x00000001:
  - Both ops -> rd=0x00828201.
  - Neither op -> out_valid=1 with rd=0.
- Backpressure, PIPE_STAGES=3:
  - Hold out_ready=0 and stream 5 ops -> exactly 3 accepted, in_ready=0, rd stable.
  - Release out_ready -> all 5 results in order at 1/cycle.
- Flush and reset:
  - Flush with 2 ops in flight -> out_valid=0 next cycle; the next accepted op emerges after PIPE_STAGES cycles.
  - g_resetn=0 mid-stream -> out_valid=0, rd=0.
- RISCV_CRYPTO_FU_SSM3_PERF_EN defined:
  - 10 completed ops plus 1 flushed -> perf_count=10.
  - Counter preset via force to 0xFFFFFFFF, then 1 op -> perf_count=0.
